// File: rtl/aux_mem_arbiter_pkg.sv
// aux_mem_arbiter_pkg: shared widths, depth and types for the aux memory arbiter.
package aux_mem_arbiter_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 8;
   localparam int AUX_DEPTH = 256;
   typedef enum logic {AUX_ST_IDLE, AUX_ST_CLEAR} aux_state_t;
   typedef enum logic {OWN_A, OWN_B} owner_t;
   typedef struct packed {
      logic   valid;
      owner_t owner;
   } rtag_t;
endpackage

// File: rtl/aux_mem_arbiter_if.sv
// aux_mem_arbiter_if: one requester port (request, write data, grant, read return).
interface aux_mem_arbiter_if import aux_mem_arbiter_pkg::*; #(
   parameter int dw = DATA_WIDTH,
   parameter int aw = ADDR_WIDTH
);
   logic          req;
   logic          we;
   logic [aw-1:0] addr;
   logic [dw-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [dw-1:0] rdata;
   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/aux_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the side not served last wins.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   logic last_b;
   assign gnt[0] = advance && req[0] && (!req[1] || last_b);
   assign gnt[1] = advance && req[1] && (!req[0] || !last_b);
   always_ff @(posedge clk)
      if (rst) last_b <= 1'b1;
      else if (|gnt) last_b <= gnt[1];
endmodule

// File: rtl/aux_mem_arbiter.sv
// aux_mem_arbiter: shares a single-port aux RAM between two requesters and
// zero-fills it on command.
module aux_mem_arbiter import aux_mem_arbiter_pkg::*; #(
   parameter int dw = DATA_WIDTH,
   parameter int aw = ADDR_WIDTH,
   parameter int depth = AUX_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   aux_mem_arbiter_if.slave a,
   aux_mem_arbiter_if.slave b,
   input  logic          clr_start,
   output logic          clr_busy,
   output logic          clr_done,
   output logic          mem_we,
   output logic [aw-1:0] mem_addr,
   output logic [dw-1:0] mem_din,
   input  logic [dw-1:0] mem_dout
);
   aux_state_t    state, state_nxt;
   logic [aw-1:0] cnt;
   logic [1:0]    gnt;
   logic          last_clr;
   logic          rd_gnt;
   rtag_t         tag0, tag1;

   assign last_clr = state == AUX_ST_CLEAR && cnt == aw'(depth - 1);
   assign clr_busy = state == AUX_ST_CLEAR;

   always_comb state_nxt = (state == AUX_ST_IDLE && clr_start) ? AUX_ST_CLEAR :
                           last_clr ? AUX_ST_IDLE : state;

   always_ff @(posedge clk) state <= rst ? AUX_ST_IDLE : state_nxt;

   // a clr_start cycle issues no grant so the clear begins from a quiet port
   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({b.req, a.req}),
      .advance (state == AUX_ST_IDLE && !clr_start && !rst),
      .gnt     (gnt)
   );

   assign a.gnt  = gnt[0];
   assign b.gnt  = gnt[1];
   assign rd_gnt = gnt[0] ? !a.we : (gnt[1] && !b.we);

   always_ff @(posedge clk)
      cnt <= (rst || state != AUX_ST_CLEAR || last_clr) ? '0 : cnt + 1'b1;

   always_ff @(posedge clk) clr_done <= !rst && last_clr;

   always_ff @(posedge clk)
      if (rst) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
      end else if (state == AUX_ST_CLEAR) begin
         mem_we   <= 1'b1;
         mem_addr <= cnt;
         mem_din  <= '0;
      end else if (|gnt) begin
         mem_we   <= gnt[0] ? a.we : b.we;
         mem_addr <= gnt[0] ? a.addr : b.addr;
         mem_din  <= gnt[0] ? a.wdata : b.wdata;
      end else
         mem_we <= 1'b0;

   // two stages: address register, then RAM output register
   always_ff @(posedge clk)
      if (rst) begin
         tag0 <= '{valid: 1'b0, owner: OWN_A};
         tag1 <= '{valid: 1'b0, owner: OWN_A};
      end else begin
         tag0 <= '{valid: rd_gnt, owner: gnt[1] ? OWN_B : OWN_A};
         tag1 <= tag0;
      end

   assign a.rvalid = tag1.valid && tag1.owner == OWN_A;
   assign b.rvalid = tag1.valid && tag1.owner == OWN_B;
   assign a.rdata  = a.rvalid ? mem_dout : '0;
   assign b.rdata  = b.rvalid ? mem_dout : '0;
endmodule
